// File: rtl/ps2_mouse_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_mouse_pkg
// Brief    : Shared state encodings and PS/2 frame/header constants.
// Revision : 1.0
// ============================================================================
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        BYTE_IDLE   = 2'd0,
        BYTE_DATA   = 2'd1,
        BYTE_PARITY = 2'd2,
        BYTE_STOP   = 2'd3
    } byte_state_t;

    typedef enum logic [1:0] {
        PKT_B0 = 2'd0,
        PKT_B1 = 2'd1,
        PKT_B2 = 2'd2
    } pkt_state_t;

    localparam int HDR_SYNC   = 3;
    localparam int HDR_XS     = 4;
    localparam int HDR_YS     = 5;
    localparam int HDR_XO     = 6;
    localparam int HDR_YO     = 7;
    localparam int FRAME_BITS = 11;

    // PS/2 uses odd parity across the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage : ps2_mouse_pkg
`default_nettype wire

// File: rtl/ps2_rx_byte.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx_byte
// Brief    : Pad synchroniser, PS/2 clock glitch filter, 11-bit byte deframer
//            and idle timeout.
// Revision : 1.0
// ============================================================================
module ps2_rx_byte
    import ps2_mouse_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       pkt_active,
    output logic       byte_rdy,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       busy
);

    localparam int               c_fw        = $clog2(FILTER_LEN + 1);
    localparam logic [c_fw-1:0]  c_filt_last = c_fw'(FILTER_LEN - 1);
    localparam int               c_tw        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tw-1:0]  c_to_last   = c_tw'(TIMEOUT_CYCLES - 1);
    localparam int               c_data_bits = FRAME_BITS - 3;
    localparam logic [2:0]       c_last_bit  = 3'(c_data_bits - 1);

    logic            r_c_meta, r_c_sync, r_d_meta, r_d_sync;
    logic            r_filt_clk;
    logic [c_fw-1:0] r_filt_cnt;
    logic            r_fall_tick;

    byte_state_t     r_state;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_par_ok;
    logic            r_byte_rdy;
    logic [7:0]      r_byte;
    logic            r_frame_err;
    logic [c_tw-1:0] r_to_cnt;

    logic            w_active;
    logic            w_timeout;

    // Lines idle high, so the synchronisers come out of reset at 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_c_meta <= 1'b1;
            r_c_sync <= 1'b1;
            r_d_meta <= 1'b1;
            r_d_sync <= 1'b1;
        end else begin
            r_c_meta <= ps2c;
            r_c_sync <= r_c_meta;
            r_d_meta <= ps2d;
            r_d_sync <= r_d_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_filt_clk  <= 1'b1;
            r_filt_cnt  <= '0;
            r_fall_tick <= 1'b0;
        end else begin
            r_fall_tick <= 1'b0;
            if (r_c_sync != r_filt_clk) begin
                if (r_filt_cnt == c_filt_last) begin
                    r_filt_clk  <= r_c_sync;
                    r_filt_cnt  <= '0;
                    r_fall_tick <= ~r_c_sync;
                end else begin
                    r_filt_cnt <= r_filt_cnt + 1'b1;
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    assign w_active  = (r_state != BYTE_IDLE) || pkt_active;
    assign w_timeout = w_active && (r_to_cnt == c_to_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= BYTE_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_ok    <= 1'b0;
            r_byte_rdy  <= 1'b0;
            r_byte      <= '0;
            r_frame_err <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_byte_rdy  <= 1'b0;
            r_frame_err <= 1'b0;

            if (!w_active || w_timeout || r_fall_tick) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            // An expired timeout wins over a clock edge landing in the same cycle.
            if (w_timeout) begin
                r_state     <= BYTE_IDLE;
                r_frame_err <= 1'b1;
            end else if (r_fall_tick) begin
                case (r_state)
                    BYTE_IDLE: begin
                        if (!r_d_sync) begin
                            r_state   <= BYTE_DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    BYTE_DATA: begin
                        r_shift   <= {r_d_sync, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_last_bit) begin
                            r_state <= BYTE_PARITY;
                        end
                    end
                    BYTE_PARITY: begin
                        r_par_ok <= odd_parity_ok(r_shift, r_d_sync);
                        r_state  <= BYTE_STOP;
                    end
                    BYTE_STOP: begin
                        if (r_d_sync && r_par_ok) begin
                            r_byte_rdy <= 1'b1;
                            r_byte     <= r_shift;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                        r_state <= BYTE_IDLE;
                    end
                    default: r_state <= BYTE_IDLE;
                endcase
            end
        end
    end

    assign byte_rdy  = r_byte_rdy;
    assign rx_byte   = r_byte;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != BYTE_IDLE);

endmodule : ps2_rx_byte
`default_nettype wire

// File: rtl/ps2_mouse_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_mouse_rx
// Brief    : PS/2 mouse receiver: 3-byte packet assembly, delta/button decode
//            and clamped horizontal position integrator.
// Revision : 1.0
// ============================================================================
module ps2_mouse_rx
    import ps2_mouse_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50_000,
    parameter int X_MIN          = 0,
    parameter int X_MAX          = 600,
    parameter int X_INIT         = 320
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic       pkt_valid,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic [2:0] btn,
    output logic [9:0] pos_x,
    output logic       frame_err
);

    localparam logic signed [10:0] c_x_min  = 11'(X_MIN);
    localparam logic signed [10:0] c_x_max  = 11'(X_MAX);
    localparam logic        [9:0]  c_x_init = 10'(X_INIT);

    if (CLK_HZ <= 0 || X_MIN < 0 || X_MAX > 1023 || X_MIN > X_MAX ||
        FILTER_LEN < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("ps2_mouse_rx: invalid parameter set");
    end

    logic        w_byte_rdy;
    logic [7:0]  w_byte;
    logic        w_frame_err;
    logic        w_busy;

    pkt_state_t  r_pkt_state;
    logic        r_hdr_xs, r_hdr_ys, r_hdr_xo, r_hdr_yo;
    logic [2:0]  r_hdr_btn;
    logic [7:0]  r_xb;
    logic        r_pkt_valid;
    logic [8:0]  r_dx, r_dy;
    logic [2:0]  r_btn;
    logic [9:0]  r_pos_x;

    logic [8:0]         w_dx_new, w_dy_new;
    logic signed [10:0] w_sum;
    logic [9:0]         w_pos_next;

    ps2_rx_byte #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx_byte (
        .clk        (clk),
        .reset      (reset),
        .ps2c       (ps2c),
        .ps2d       (ps2d),
        .pkt_active (r_pkt_state != PKT_B0),
        .byte_rdy   (w_byte_rdy),
        .rx_byte    (w_byte),
        .frame_err  (w_frame_err),
        .busy       (w_busy)
    );

    // In B2 the incoming byte is the Y byte, so decode uses it directly.
    assign w_dx_new = r_hdr_xo ? 9'd0 : {r_hdr_xs, r_xb};
    assign w_dy_new = r_hdr_yo ? 9'd0 : {r_hdr_ys, w_byte};
    assign w_sum    = $signed({1'b0, r_pos_x}) + $signed({{2{w_dx_new[8]}}, w_dx_new});

    always_comb begin
        w_pos_next = w_sum[9:0];
        if (w_sum < c_x_min) begin
            w_pos_next = c_x_min[9:0];
        end else if (w_sum > c_x_max) begin
            w_pos_next = c_x_max[9:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pkt_state <= PKT_B0;
            r_hdr_xs    <= 1'b0;
            r_hdr_ys    <= 1'b0;
            r_hdr_xo    <= 1'b0;
            r_hdr_yo    <= 1'b0;
            r_hdr_btn   <= '0;
            r_xb        <= '0;
            r_pkt_valid <= 1'b0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_btn       <= '0;
            r_pos_x     <= c_x_init;
        end else begin
            r_pkt_valid <= 1'b0;
            if (w_frame_err) begin
                r_pkt_state <= PKT_B0;
            end else if (w_byte_rdy) begin
                case (r_pkt_state)
                    PKT_B0: begin
                        // Bit 3 is always set in a header; anything else is a resync drop.
                        if (w_byte[HDR_SYNC]) begin
                            r_hdr_xs    <= w_byte[HDR_XS];
                            r_hdr_ys    <= w_byte[HDR_YS];
                            r_hdr_xo    <= w_byte[HDR_XO];
                            r_hdr_yo    <= w_byte[HDR_YO];
                            r_hdr_btn   <= w_byte[2:0];
                            r_pkt_state <= PKT_B1;
                        end
                    end
                    PKT_B1: begin
                        r_xb        <= w_byte;
                        r_pkt_state <= PKT_B2;
                    end
                    PKT_B2: begin
                        r_pkt_valid <= 1'b1;
                        r_dx        <= w_dx_new;
                        r_dy        <= w_dy_new;
                        r_btn       <= r_hdr_btn;
                        r_pos_x     <= w_pos_next;
                        r_pkt_state <= PKT_B0;
                    end
                    default: r_pkt_state <= PKT_B0;
                endcase
            end
        end
    end

    assign pkt_valid = r_pkt_valid;
    assign dx        = r_dx;
    assign dy        = r_dy;
    assign btn       = r_btn;
    assign pos_x     = r_pos_x;
    assign frame_err = w_frame_err;

endmodule : ps2_mouse_rx
`default_nettype wire
